// File: rtl/mul.sv
// Radix-2 shift-add multiplier (MULT/MULTU) for the execute stage, start/ready handshake.
// Latency: ready low for exactly WIDTH cycles; product_hi/lo registered and held until the next result.
module mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 last;

    // Magnitudes are unsigned WIDTH-bit, so |min-int| still fits.
    assign mag_a   = (sign && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    assign mag_b   = (sign && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last    = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                neg_d    = sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                mcand_d  = {{WIDTH{1'b0}}, mag_a};
                mplier_d = mag_b;
                acc_d    = '0;
                cnt_d    = '0;
            end
        end else begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // Final iteration folds straight into the signed product register.
            if (last) begin
                prod_d = neg_q ? -acc_sum : acc_sum;
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        ready      = (state_q == IDLE);
        done       = done_q;
        product_hi = prod_q[2*WIDTH-1:WIDTH];
        product_lo = prod_q[WIDTH-1:0];
    end

endmodule
